vrf_operand_fetch: RTL and testbench

VRF_OPERAND_FETCH -- requirements
Module: vrf_operand_fetch

---
 rtl/vpu_pkg.sv | 20 ++
 rtl/vof_mask_gen.sv | 28 ++
 rtl/vrf_operand_fetch.sv | 149 ++++++++++++++
 tb/tb_vrf_operand_fetch.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_pkg.sv
// Shared VPU constants and the operand-fetch FSM state encoding.
package vpu_pkg;

   localparam int unsigned NBANK    = 8;
   localparam int unsigned DEPTH    = 128;
   localparam int unsigned EW       = 32;
   localparam int unsigned AW       = 7;
   localparam int unsigned VLEN_W   = 11;
   localparam int unsigned VLEN_MAX = 1024;

   typedef enum logic [2:0] {
      StIdle,
      StRdA,
      StRdB,
      StCapB,
      StPresent,
      StDone
   } vof_state_e;

endpackage

// File: rtl/vof_mask_gen.sv
// Tail-mask generation: active lanes and last-row flag for a given row of a vector.
module vof_mask_gen
   import vpu_pkg::*;
#(
   parameter int unsigned NBANK = vpu_pkg::NBANK
) (
   input  logic [VLEN_W-1:0] i_vlen,
   input  logic [AW-1:0]     i_row,
   output logic [NBANK-1:0]  o_mask,
   output logic              o_last
);

   logic [31:0] w_rows;
   logic [31:0] w_rem;

   always_comb begin
      w_rows = (32'(i_vlen) + NBANK - 1) / NBANK;
      w_rem  = 32'(i_vlen) % NBANK;
      o_last = ((32'(i_row) + 32'd1) == w_rows);
      // A full final row (rem == 0) keeps every lane.
      if (!o_last || (w_rem == 32'd0)) begin
         o_mask = '1;
      end else begin
         o_mask = NBANK'((32'd1 << w_rem) - 32'd1);
      end
   end

endmodule

// File: rtl/vrf_operand_fetch.sv
// Fetches operand row pairs from the VRF (A then B per row) and presents them to the lanes.
module vrf_operand_fetch
   import vpu_pkg::*;
#(
   parameter int unsigned NBANK = vpu_pkg::NBANK,
   parameter int unsigned DEPTH = vpu_pkg::DEPTH,
   parameter int unsigned EW    = vpu_pkg::EW
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                start_valid,
   output logic                start_ready,
   input  logic [AW-1:0]       src1_base,
   input  logic [AW-1:0]       src2_base,
   input  logic [VLEN_W-1:0]   vlen,
   output logic                vrf_read,
   output logic [AW-1:0]       vrf_addr,
   input  logic [NBANK*EW-1:0] vrf_rdata,
   output logic                op_valid,
   input  logic                op_ready,
   output logic [NBANK*EW-1:0] op_a,
   output logic [NBANK*EW-1:0] op_b,
   output logic [NBANK-1:0]    op_mask,
   output logic                op_last,
   output logic                busy,
   output logic                done
);

   vof_state_e          r_state;
   vof_state_e          w_state_d;
   logic [AW-1:0]       r_src1;
   logic [AW-1:0]       r_src2;
   logic [AW-1:0]       r_row;
   logic [VLEN_W-1:0]   r_vlen;
   logic [NBANK*EW-1:0] r_op_a;
   logic [NBANK*EW-1:0] r_op_b;

   logic [VLEN_W-1:0]   w_vlen_clamped;
   logic [NBANK-1:0]    w_mask;
   logic                w_last;
   logic [NBANK*EW-1:0] w_lane_keep;
   logic [AW-1:0]       w_base;
   logic [AW:0]         w_addr_sum;
   logic [AW-1:0]       w_addr;

   assign w_vlen_clamped = (vlen > VLEN_W'(VLEN_MAX)) ? VLEN_W'(VLEN_MAX) : vlen;

   vof_mask_gen #(
      .NBANK (NBANK)
   ) u_mask_gen (
      .i_vlen (r_vlen),
      .i_row  (r_row),
      .o_mask (w_mask),
      .o_last (w_last)
   );

   always_comb begin
      w_lane_keep = '0;
      for (int k = 0; k < int'(NBANK); k++) begin
         w_lane_keep[k*EW +: EW] = {EW{w_mask[k]}};
      end
   end

   // Base addresses wrap around the bank depth.
   assign w_base     = (r_state == StRdB) ? r_src2 : r_src1;
   assign w_addr_sum = {1'b0, w_base} + {1'b0, r_row};
   assign w_addr     = AW'(32'(w_addr_sum) % DEPTH);

   always_comb begin
      w_state_d   = r_state;
      start_ready = 1'b0;
      vrf_read    = 1'b0;
      vrf_addr    = '0;
      op_valid    = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      unique case (r_state)
         StIdle: begin
            busy        = 1'b0;
            start_ready = 1'b1;
            if (start_valid) begin
               w_state_d = (vlen == '0) ? StDone : StRdA;
            end
         end
         StRdA: begin
            vrf_read  = 1'b1;
            vrf_addr  = w_addr;
            w_state_d = StRdB;
         end
         StRdB: begin
            vrf_read  = 1'b1;
            vrf_addr  = w_addr;
            w_state_d = StCapB;
         end
         StCapB: begin
            w_state_d = StPresent;
         end
         StPresent: begin
            op_valid = 1'b1;
            if (op_ready) begin
               w_state_d = w_last ? StDone : StRdA;
            end
         end
         StDone: begin
            done      = 1'b1;
            w_state_d = StIdle;
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   assign op_a    = op_valid ? r_op_a : '0;
   assign op_b    = op_valid ? r_op_b : '0;
   assign op_mask = op_valid ? w_mask : '0;
   assign op_last = op_valid & w_last;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= StIdle;
         r_src1  <= '0;
         r_src2  <= '0;
         r_vlen  <= '0;
         r_row   <= '0;
         r_op_a  <= '0;
         r_op_b  <= '0;
      end else begin
         r_state <= w_state_d;
         if ((r_state == StIdle) && start_valid) begin
            r_src1 <= src1_base;
            r_src2 <= src2_base;
            r_vlen <= w_vlen_clamped;
            r_row  <= '0;
         end
         if ((r_state == StPresent) && op_ready && !w_last) begin
            r_row <= r_row + AW'(1);
         end
         // Read data lags the strobe by one cycle: A lands in RD_B, B lands in CAP_B.
         if (r_state == StRdB) begin
            r_op_a <= vrf_rdata & w_lane_keep;
         end
         if (r_state == StCapB) begin
            r_op_b <= vrf_rdata & w_lane_keep;
         end
      end
   end

endmodule

// File: tb/tb_vrf_operand_fetch.sv
// Self-checking bench for vrf_operand_fetch: directed table, random requests and reset abort.
module tb_vrf_operand_fetch;
   import vpu_pkg::*;

   localparam int unsigned DW = NBANK * EW;

   typedef struct {
      logic [AW-1:0]     s1;
      logic [AW-1:0]     s2;
      logic [VLEN_W-1:0] vlen;
      int                mode;     // 0: ready always, 1: random ready, 2: stall 5 per row
      int                exp_rows; // -1 when not hand-specified
      logic [NBANK-1:0]  exp_tail;
   } vec_t;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic              start_valid = 1'b0;
   logic              start_ready;
   logic [AW-1:0]     src1_base = '0;
   logic [AW-1:0]     src2_base = '0;
   logic [VLEN_W-1:0] vlen = '0;
   logic              vrf_read;
   logic [AW-1:0]     vrf_addr;
   logic [DW-1:0]     vrf_rdata = '0;
   logic              op_valid;
   logic              op_ready = 1'b0;
   logic [DW-1:0]     op_a;
   logic [DW-1:0]     op_b;
   logic [NBANK-1:0]  op_mask;
   logic              op_last;
   logic              busy;
   logic              done;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] mem [DEPTH];

   vrf_operand_fetch dut (
      .clk         (clk),
      .rstn        (rstn),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .src1_base   (src1_base),
      .src2_base   (src2_base),
      .vlen        (vlen),
      .vrf_read    (vrf_read),
      .vrf_addr    (vrf_addr),
      .vrf_rdata   (vrf_rdata),
      .op_valid    (op_valid),
      .op_ready    (op_ready),
      .op_a        (op_a),
      .op_b        (op_b),
      .op_mask     (op_mask),
      .op_last     (op_last),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rand_row();
      logic [DW-1:0] d;
      for (int k = 0; k < int'(NBANK); k++) d[k*EW +: EW] = EW'($urandom());
      return d;
   endfunction

   // VRF: data for a strobed address appears the next cycle; garbage otherwise.
   always @(posedge clk) begin
      if (vrf_read) vrf_rdata <= mem[vrf_addr];
      else          vrf_rdata <= rand_row();
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 30) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Element-level model: element e of the row exists iff r*NBANK+k < n.
   function automatic logic [DW-1:0] model_row(input logic [AW-1:0] base, input int r,
                                                input int n);
      logic [DW-1:0] d;
      d = mem[(int'(base) + r) % DEPTH];
      for (int k = 0; k < int'(NBANK); k++) begin
         if (r * int'(NBANK) + k >= n) d[k*EW +: EW] = '0;
      end
      return d;
   endfunction

   function automatic logic [NBANK-1:0] model_mask(input int r, input int n);
      logic [NBANK-1:0] m;
      for (int k = 0; k < int'(NBANK); k++) m[k] = (r * int'(NBANK) + k < n);
      return m;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_start_ready"}, start_ready, 1'b1);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_vrf_read"}, vrf_read, 1'b0);
      check({tag, "_vrf_addr"}, vrf_addr, '0);
      check({tag, "_op_valid"}, op_valid, 1'b0);
      check({tag, "_op_a"}, op_a, '0);
      check({tag, "_op_b"}, op_b, '0);
      check({tag, "_op_mask"}, op_mask, '0);
      check({tag, "_op_last"}, op_last, 1'b0);
   endtask

   task automatic run_vec(input vec_t v, input bit noisy);
      int n, rows, row, cyc, stall, last_hs, rd_idx, budget;
      bit got_done, busy_ok, idle_addr_ok, present_rd_ok;
      logic [AW-1:0] exp_addr;
      logic [NBANK-1:0] tail;
      n = (int'(v.vlen) > int'(VLEN_MAX)) ? int'(VLEN_MAX) : int'(v.vlen);
      rows = (n + int'(NBANK) - 1) / int'(NBANK);
      budget = 12 * rows + 20;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] = rand_row();
      @(negedge clk);
      check("start_ready_idle", start_ready, 1'b1);
      start_valid = 1'b1;
      src1_base   = v.s1;
      src2_base   = v.s2;
      vlen        = v.vlen;
      @(negedge clk);
      start_valid = noisy;
      row = 0; cyc = 1; stall = 0; last_hs = -1; rd_idx = 0; tail = '0;
      got_done = 0; busy_ok = 1; idle_addr_ok = 1; present_rd_ok = 1;
      while (!got_done && cyc <= budget) begin
         if (noisy) begin
            src1_base = AW'($urandom());
            src2_base = AW'($urandom());
            vlen      = VLEN_W'($urandom());
         end
         if (busy !== 1'b1) busy_ok = 0;
         if (vrf_read) begin
            exp_addr = AW'((int'((rd_idx % 2) != 0 ? v.s2 : v.s1) + rd_idx / 2) % DEPTH);
            check("vrf_addr", vrf_addr, exp_addr);
            rd_idx++;
         end else if (vrf_addr !== '0) begin
            idle_addr_ok = 0;
         end
         if (op_valid) begin
            if (vrf_read) present_rd_ok = 0;
            check("op_a", op_a, model_row(v.s1, row, n));
            check("op_b", op_b, model_row(v.s2, row, n));
            check("op_mask", op_mask, model_mask(row, n));
            check("op_last", op_last, row == rows - 1);
            if (op_last) tail = op_mask;
            case (v.mode)
               0:       op_ready = 1'b1;
               1:       op_ready = 1'($urandom_range(0, 1));
               default: op_ready = (stall >= 5);
            endcase
            if (op_ready) begin
               last_hs = cyc;
               row++;
               stall = 0;
            end else begin
               stall++;
            end
         end else begin
            op_ready = 1'($urandom_range(0, 1));
         end
         if (done) begin
            got_done = 1;
            start_valid = 1'b0;
            check("done_timing", cyc, (rows == 0) ? 1 : last_hs + 1);
            if (v.mode == 0) check("cycles_per_row", cyc, 4 * rows + 1);
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      start_valid = 1'b0;
      check("done_seen", got_done, 1'b1);
      check("rows_presented", row, rows);
      check("read_count", rd_idx, 2 * rows);
      check("busy_while_active", busy_ok, 1'b1);
      check("vrf_addr_zero_idle", idle_addr_ok, 1'b1);
      check("no_read_in_present", present_rd_ok, 1'b1);
      if (v.exp_rows >= 0) begin
         check("table_rows", row, v.exp_rows);
         check("table_tail_mask", tail, v.exp_tail);
      end
      @(negedge clk);
      check("start_ready_after_done", start_ready, 1'b1);
      check("busy_after_done", busy, 1'b0);
      check("done_one_cycle", done, 1'b0);
   endtask

   task automatic reset_abort_test();
      int waited;
      bit found, done_seen;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] = rand_row();
      op_ready = 1'b1;
      @(negedge clk);
      start_valid = 1'b1;
      src1_base   = 7'd20;
      src2_base   = 7'd90;
      vlen        = 11'd64;
      @(negedge clk);
      start_valid = 1'b0;
      found = 0;
      waited = 0;
      // RD_B of row index 3 reads src2+3.
      while (!found && waited < 100) begin
         if (vrf_read && vrf_addr == 7'd93) found = 1;
         else begin
            @(negedge clk);
            waited++;
         end
      end
      check("reset_reach_rd_b_row3", found, 1'b1);
      rstn = 1'b0;
      #1;
      check_reset_outputs("abort");
      done_seen = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) done_seen = 1;
      end
      check("abort_no_done", done_seen, 1'b0);
      rstn = 1'b1;
      #1;
      check_reset_outputs("after_release");
   endtask

   vec_t vecs[10];

   initial begin
      vecs[0] = '{7'd5,   7'd40,  11'd16,   0, 2,   8'hFF};
      vecs[1] = '{7'd0,   7'd64,  11'd3,    0, 1,   8'h07};
      vecs[2] = '{7'd9,   7'd9,   11'd0,    0, 0,   8'h00};
      vecs[3] = '{7'd127, 7'd3,   11'd16,   0, 2,   8'hFF};
      vecs[4] = '{7'd10,  7'd20,  11'd13,   1, 2,   8'h1F};
      vecs[5] = '{7'd33,  7'd66,  11'd21,   2, 3,   8'h1F};
      vecs[6] = '{7'd1,   7'd2,   11'd1025, 0, 128, 8'hFF};
      vecs[7] = '{7'd100, 7'd50,  11'd2047, 1, 128, 8'hFF};
      vecs[8] = '{7'd7,   7'd7,   11'd8,    0, 1,   8'hFF};
      vecs[9] = '{7'd120, 7'd126, 11'd1023, 2, 128, 8'h7F};

      #1;
      check_reset_outputs("reset");
      repeat (3) @(negedge clk);
      rstn = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(vecs[i], bit'(i % 2));

      for (int i = 0; i < 20; i++) begin
         vec_t r;
         r.s1       = AW'($urandom());
         r.s2       = AW'($urandom());
         r.vlen     = ($urandom_range(0, 4) == 0) ? VLEN_W'($urandom())
                                                  : VLEN_W'($urandom_range(0, 80));
         r.mode     = $urandom_range(0, 2);
         r.exp_rows = -1;
         r.exp_tail = '0;
         run_vec(r, bit'($urandom_range(0, 1)));
      end

      reset_abort_test();
      run_vec(vecs[0], 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
